avg_filter_3x3_core: RTL and testbench
======================================

// Module: avg_filter_3x3_core
// PURPOSE
//  Consumer of the 3x3 pixel window from the line-buffer window generator in the ball-locator pixel path.
//  Computes floor(mean of 9 pixels) per window in a fixed-latency pipeline.
//  Tracks column/row position, flags the 2-pixel-deep top/left border where the window is incomplete,
//  and emits one filtered pixel per input strobe to the downstream centroid logic.
// PARAMETERS
//  IMG_WIDTH   640  pixels per line; column counter wraps at IMG_WIDTH-1
//  IMG_HEIGHT  480  lines per frame; row counter wraps at IMG_HEIGHT-1
//  BORDER_VAL  8'h00  dout value driven for border pixels
// PORTS
//  clk_100M     in   1   system clock
//  rst_p        in   1   reset: asynchronous, active-high
//  filter_en    in   1   block enable; low = flush and hold idle
//  pix_valid    in   1   pixel strobe; same strobe that shift-enables the window generator
//  frame_start  in   1   one-cycle pulse at frame start; clears position counters
//  p11..p33     in   8   each; 3x3 window (p11 oldest row/col); valid the cycle after pix_valid
//  threshold    in   8   binarisation level; used only with BINARY_THRESHOLD_EN
//  dout         out  8   filtered pixel
//  dout_valid   out  1   dout strobe, one cycle per pix_valid
//  border_flag  out  1   qualifies dout: window incomplete, dout=BORDER_VAL
// BEHAVIOUR
//  - Reset: dout=0, dout_valid=0, border_flag=0; counters, pipeline regs and valid shift chain = 0.
//  - win_stb = pix_valid registered 1 cycle, aligned with the window update.
//  - Pipeline, all stages advance every cycle, no stall:
//      S1 row sums, 10 b each; S2 total sum, 12 b, max 2295;
//      S3 prod = sum*13'd7282, 25 b; S4 dout = prod[23:16].
//  - prod[23:16] equals floor(sum/9) exactly for sum 0..2295.
//  - Latency: pix_valid in cycle N -> dout_valid in cycle N+5.
//  - Throughput: 1 pixel/cycle. Back-to-back strobes give back-to-back outputs.
//  - Position counters col_cnt/row_cnt advance on win_stb:
//      col wraps IMG_WIDTH-1 -> 0 and then increments row; row wraps IMG_HEIGHT-1 -> 0.
//  - Border condition = (row_cnt<2) || (col_cnt<2), sampled with win_stb.
//      It travels down the pipeline with the data.
//      At output: border_flag=1, dout=BORDER_VAL.
//  - frame_start has priority over counter increment.
//      frame_start with win_stb in the same cycle: that pixel is (col 0, row 0); counters go to (1,0).
//      frame_start alone: counters go to (0,0).
//  - filter_en=0: synchronously clears counters, valid chain and data regs.
//      Outputs are 0 from the next cycle.
//      In-flight pixels are dropped, never emitted.
//  - filter_en rising: counting restarts at (0,0); no frame_start is needed.
//  - rst_p mid-frame: everything clears immediately; pipeline contents are lost.
//  - pix_valid while filter_en=0: ignored.
//  - dout/border_flag hold their last value while dout_valid=0.
// CONFIGURATION
//  BINARY_THRESHOLD_EN defined:
//    - Non-border: S4 dout = (avg >= threshold) ? 8'hFF : 8'h00.
//    - Border: dout = 8'h00.
//    - threshold is sampled in S3 (the multiply stage); latency is unchanged.
//  BINARY_THRESHOLD_EN undefined:
//    - dout = avg; threshold port is unused; no compare logic.
// TESTING
//  (IMG_WIDTH=8, IMG_HEIGHT=6 for all scenarios)
//  1 Uniform: all p=90, continuous pix_valid from frame_start -> non-border dout=90, 5 cycles after each strobe.
//  2 Arithmetic corners:
//      all 255 -> 255; all 0 -> 0;
//      eight 2s + one 1 (sum 17) -> 1;
//      sum 18 -> 2; sum 2294 -> 254.
//  3 Border map: full 8x6 frame -> border_flag=1 exactly for rows 0-1 and cols 0-1 of each row.
//      Count: 2*8 + 4*2 = 24 flagged pixels, with dout=0; 24 unflagged.
//  4 Gapped strobes: pix_valid every 3rd cycle -> outputs every 3rd cycle, each at N+5;
//      counters advance only on strobes.
//  5 filter_en low for 1 cycle with 3 pixels in flight -> none emitted;
//      next strobe is treated as (0,0) and flagged as border.
//  6 Async rst_p pulse mid-frame -> outputs 0 within the same cycle; counters restart at (0,0).
//  7 BINARY_THRESHOLD_EN, all p=100:
//      threshold=100 -> dout=FF; threshold=101 -> dout=00; border pixels -> 00.

Source files
------------

// File: rtl/avg_filter_3x3_core.sv
// -----------------------------------------------------------------------------
// avg_filter_3x3_core
//
// Purpose:
//   3x3 box (mean) filter for the ball-locator pixel path. Takes the 3x3
//   window from the line-buffer window generator and produces floor(mean of 9)
//   per window in a fixed five-cycle pipeline with no stalls. It also tracks
//   column/row position and flags the two-pixel-deep top/left border, where
//   the window is still incomplete.
//
// Optional feature (macro BINARY_THRESHOLD_EN):
//   When defined, non-border outputs are binarised against i threshold
//   (avg >= threshold -> 8'hFF, else 8'h00) and border pixels output 8'h00.
//   When undefined, dout is the plain average and threshold is unused.
//
// Ports:
//   clk_100M     in   1  system clock
//   rst_p        in   1  asynchronous active-high reset
//   filter_en    in   1  block enable; low flushes the pipeline and counters
//   pix_valid    in   1  pixel strobe (also shift-enables the window generator)
//   frame_start  in   1  one-cycle pulse, clears the position counters
//   p11..p33     in   8  3x3 window, valid the cycle after pix_valid
//   threshold    in   8  binarisation level (BINARY_THRESHOLD_EN only)
//   dout         out  8  filtered pixel, held while dout_valid is low
//   dout_valid   out  1  one strobe per accepted pix_valid, 5 cycles later
//   border_flag  out  1  dout belongs to an incomplete (border) window
// -----------------------------------------------------------------------------
module avg_filter_3x3_core #(
  parameter int          IMG_WIDTH  = 640,
  parameter int          IMG_HEIGHT = 480,
  parameter logic [7:0]  BORDER_VAL = 8'h00
) (
  input  logic        clk_100M,
  input  logic        rst_p,
  input  logic        filter_en,
  input  logic        pix_valid,
  input  logic        frame_start,
  input  logic [7:0]  p11,
  input  logic [7:0]  p12,
  input  logic [7:0]  p13,
  input  logic [7:0]  p21,
  input  logic [7:0]  p22,
  input  logic [7:0]  p23,
  input  logic [7:0]  p31,
  input  logic [7:0]  p32,
  input  logic [7:0]  p33,
  input  logic [7:0]  threshold,
  output logic [7:0]  dout,
  output logic        dout_valid,
  output logic        border_flag
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  // 7282/65536 approximates 1/9 closely enough that prod[23:16] is exactly
  // floor(sum/9) over the whole 0..2295 sum range.
  localparam logic [24:0] RECIP9 = 25'd7282;

  function automatic logic [24:0] mul_recip9(input logic [11:0] sum);
    return 25'(sum) * RECIP9;
  endfunction

`ifdef BINARY_THRESHOLD_EN
  function automatic logic [7:0] out_pix(input logic [7:0] avg, input logic bdr,
                                         input logic [7:0] thr);
    if (bdr) return 8'h00;
    return (avg >= thr) ? 8'hFF : 8'h00;
  endfunction
`else
  function automatic logic [7:0] out_pix(input logic [7:0] avg, input logic bdr);
    return bdr ? BORDER_VAL : avg;
  endfunction
`endif

  logic          r_win_stb;
  logic [CW-1:0] r_col_cnt;
  logic [RW-1:0] r_row_cnt;
  logic [CW-1:0] w_col_cur;
  logic [RW-1:0] w_row_cur;
  logic          w_border;

  logic [9:0]    r_rs0_p1, r_rs1_p1, r_rs2_p1;
  logic          r_vld_p1, r_bdr_p1;
  logic [11:0]   r_sum_p2;
  logic          r_vld_p2, r_bdr_p2;
  logic [24:0]   r_prod_p3;
  logic          r_vld_p3, r_bdr_p3;
`ifdef BINARY_THRESHOLD_EN
  logic [7:0]    r_thr_p3;
`endif
  logic          w_unused;

  // frame_start overrides the stored position, so a window arriving in the
  // same cycle is treated as pixel (0,0).
  always_comb begin
    w_col_cur = frame_start ? '0 : r_col_cnt;
    w_row_cur = frame_start ? '0 : r_row_cnt;
    w_border  = (int'(w_col_cur) < 2) || (int'(w_row_cur) < 2);
  end

  // ---- stage 0: window strobe and position counters ----
  always_ff @(posedge clk_100M or posedge rst_p) begin
    if (rst_p) begin
      r_win_stb <= 1'b0;
      r_col_cnt <= '0;
      r_row_cnt <= '0;
    end else if (!filter_en) begin
      r_win_stb <= 1'b0;
      r_col_cnt <= '0;
      r_row_cnt <= '0;
    end else begin
      r_win_stb <= pix_valid;
      if (r_win_stb) begin
        if (w_col_cur == COL_LAST) begin
          r_col_cnt <= '0;
          r_row_cnt <= (w_row_cur == ROW_LAST) ? '0 : w_row_cur + RW'(1);
        end else begin
          r_col_cnt <= w_col_cur + CW'(1);
          r_row_cnt <= w_row_cur;
        end
      end else if (frame_start) begin
        r_col_cnt <= '0;
        r_row_cnt <= '0;
      end
    end
  end

  // ---- stage 1: row sums ----
  always_ff @(posedge clk_100M or posedge rst_p) begin
    if (rst_p) begin
      r_rs0_p1 <= '0;
      r_rs1_p1 <= '0;
      r_rs2_p1 <= '0;
      r_vld_p1 <= 1'b0;
      r_bdr_p1 <= 1'b0;
    end else if (!filter_en) begin
      r_rs0_p1 <= '0;
      r_rs1_p1 <= '0;
      r_rs2_p1 <= '0;
      r_vld_p1 <= 1'b0;
      r_bdr_p1 <= 1'b0;
    end else begin
      r_rs0_p1 <= 10'(p11) + 10'(p12) + 10'(p13);
      r_rs1_p1 <= 10'(p21) + 10'(p22) + 10'(p23);
      r_rs2_p1 <= 10'(p31) + 10'(p32) + 10'(p33);
      r_vld_p1 <= r_win_stb;
      r_bdr_p1 <= w_border;
    end
  end

  // ---- stage 2: total sum ----
  always_ff @(posedge clk_100M or posedge rst_p) begin
    if (rst_p) begin
      r_sum_p2 <= '0;
      r_vld_p2 <= 1'b0;
      r_bdr_p2 <= 1'b0;
    end else if (!filter_en) begin
      r_sum_p2 <= '0;
      r_vld_p2 <= 1'b0;
      r_bdr_p2 <= 1'b0;
    end else begin
      r_sum_p2 <= 12'(r_rs0_p1) + 12'(r_rs1_p1) + 12'(r_rs2_p1);
      r_vld_p2 <= r_vld_p1;
      r_bdr_p2 <= r_bdr_p1;
    end
  end

  // ---- stage 3: multiply by reciprocal of 9 ----
  always_ff @(posedge clk_100M or posedge rst_p) begin
    if (rst_p) begin
      r_prod_p3 <= '0;
      r_vld_p3  <= 1'b0;
      r_bdr_p3  <= 1'b0;
`ifdef BINARY_THRESHOLD_EN
      r_thr_p3  <= '0;
`endif
    end else if (!filter_en) begin
      r_prod_p3 <= '0;
      r_vld_p3  <= 1'b0;
      r_bdr_p3  <= 1'b0;
`ifdef BINARY_THRESHOLD_EN
      r_thr_p3  <= '0;
`endif
    end else begin
      r_prod_p3 <= mul_recip9(r_sum_p2);
      r_vld_p3  <= r_vld_p2;
      r_bdr_p3  <= r_bdr_p2;
`ifdef BINARY_THRESHOLD_EN
      r_thr_p3  <= threshold;
`endif
    end
  end

  // ---- stage 4: output register, holds between strobes ----
  always_ff @(posedge clk_100M or posedge rst_p) begin
    if (rst_p) begin
      dout        <= '0;
      dout_valid  <= 1'b0;
      border_flag <= 1'b0;
    end else if (!filter_en) begin
      dout        <= '0;
      dout_valid  <= 1'b0;
      border_flag <= 1'b0;
    end else begin
      dout_valid <= r_vld_p3;
      if (r_vld_p3) begin
`ifdef BINARY_THRESHOLD_EN
        dout <= out_pix(r_prod_p3[23:16], r_bdr_p3, r_thr_p3);
`else
        dout <= out_pix(r_prod_p3[23:16], r_bdr_p3);
`endif
        border_flag <= r_bdr_p3;
      end
    end
  end

  // Product bits outside [23:16] (and threshold in the plain build) carry no
  // information for the output.
`ifdef BINARY_THRESHOLD_EN
  assign w_unused = ^{r_prod_p3[24], r_prod_p3[15:0]};
`else
  assign w_unused = ^{threshold, r_prod_p3[24], r_prod_p3[15:0]};
`endif

endmodule

// File: tb/tb_avg_filter_3x3_core.sv
// -----------------------------------------------------------------------------
// tb_avg_filter_3x3_core
//
// Purpose:
//   Self-checking bench for avg_filter_3x3_core on an 8x6 image. A reference
//   model tracks frame position with plain integer arithmetic, computes each
//   pixel's expected output as sum/9 (or border value / threshold result when
//   BINARY_THRESHOLD_EN is defined) and queues it with its due cycle. Every
//   cycle the outputs are compared with the queue head or the held value.
// -----------------------------------------------------------------------------
module tb_avg_filter_3x3_core;

  localparam int W = 8;
  localparam int H = 6;
  localparam logic [7:0] BVAL = 8'h00;

  logic       clk_100M;
  logic       rst_p;
  logic       filter_en;
  logic       pix_valid;
  logic       frame_start;
  logic [7:0] pw [9];
  logic [7:0] threshold;
  logic [7:0] dout;
  logic       dout_valid;
  logic       border_flag;

  avg_filter_3x3_core #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .BORDER_VAL (BVAL)
  ) dut (
    .clk_100M    (clk_100M),
    .rst_p       (rst_p),
    .filter_en   (filter_en),
    .pix_valid   (pix_valid),
    .frame_start (frame_start),
    .p11 (pw[0]), .p12 (pw[1]), .p13 (pw[2]),
    .p21 (pw[3]), .p22 (pw[4]), .p23 (pw[5]),
    .p31 (pw[6]), .p32 (pw[7]), .p33 (pw[8]),
    .threshold   (threshold),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .border_flag (border_flag)
  );

  initial clk_100M = 1'b0;
  always #5 clk_100M = ~clk_100M;

  typedef struct {
    int         due;
    logic [7:0] d;
    logic       b;
  } exp_t;

  exp_t       q[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         mx = 0;
  int         my = 0;
  bit         prev_stb = 0;
  logic [7:0] last_d = 8'h00;
  logic       last_b = 1'b0;
  logic [7:0] next_win [9];
  logic [7:0] pend_win [9];
  logic [7:0] thr = 8'd100;
  int         flag_cnt = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  function automatic logic [7:0] exp_val(input int s, input bit b);
`ifdef BINARY_THRESHOLD_EN
    if (b) return 8'h00;
    return ((s / 9) >= int'(thr)) ? 8'hFF : 8'h00;
`else
    if (b) return BVAL;
    return 8'(s / 9);
`endif
  endfunction

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < 9; i++) next_win[i] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 9; i++) next_win[i] = 8'($urandom_range(0, 255));
  endtask

  // Advance one clock, then compare outputs with the model.
  task automatic tick_check();
    logic       ev;
    logic [7:0] ed;
    logic       eb;
    @(posedge clk_100M);
    cyc++;
    #1;
    if (q.size() > 0 && q[0].due == cyc) begin
      ev = 1'b1; ed = q[0].d; eb = q[0].b;
      last_d = ed; last_b = eb;
      void'(q.pop_front());
    end else begin
      ev = 1'b0; ed = last_d; eb = last_b;
    end
    if (dout_valid === 1'b1 && border_flag === 1'b1) flag_cnt++;
    chk("dout_valid", {7'd0, dout_valid}, {7'd0, ev});
    chk("dout", dout, ed);
    chk("border_flag", {7'd0, border_flag}, {7'd0, eb});
  endtask

  // Drive one cycle of inputs; the window of the previous strobe is applied now.
  task automatic step(input bit pv, input bit fs, input bit en);
    int s;
    bit b;
    exp_t e;
    for (int i = 0; i < 9; i++) pw[i] = pend_win[i];
    pix_valid   = pv;
    frame_start = fs;
    filter_en   = en;
    threshold   = thr;
    if (!en) begin
      mx = 0; my = 0;
      q.delete();
      last_d = 8'h00; last_b = 1'b0;
    end else if (prev_stb) begin
      if (fs) begin mx = 0; my = 0; end
      s = 0;
      for (int i = 0; i < 9; i++) s += int'(pend_win[i]);
      b = (mx < 2) || (my < 2);
      e.due = cyc + 4;
      e.d   = exp_val(s, b);
      e.b   = b;
      q.push_back(e);
      mx++;
      if (mx == W) begin
        mx = 0;
        my++;
        if (my == H) my = 0;
      end
    end else if (fs) begin
      mx = 0; my = 0;
    end
    prev_stb = pv && en;
    if (pv) for (int i = 0; i < 9; i++) pend_win[i] = next_win[i];
    tick_check();
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) step(0, 0, 1);
  endtask

  task automatic rand_stream(input int n);
    for (int i = 0; i < n; i++) begin
      fill_rand();
      step(1, 0, 1);
    end
  endtask

  task automatic async_reset();
    pix_valid   = 1'b0;
    frame_start = 1'b0;
    #2 rst_p = 1'b1;
    #1;
    chk("rst_dout", dout, 8'h00);
    chk("rst_dout_valid", {7'd0, dout_valid}, 8'h00);
    chk("rst_border_flag", {7'd0, border_flag}, 8'h00);
    #1 rst_p = 1'b0;
    q.delete();
    mx = 0; my = 0;
    prev_stb = 0;
    last_d = 8'h00; last_b = 1'b0;
  endtask

  initial begin
    rst_p = 1'b1;
    filter_en = 1'b0;
    pix_valid = 1'b0;
    frame_start = 1'b0;
    threshold = thr;
    for (int i = 0; i < 9; i++) begin
      pw[i] = 8'h00; next_win[i] = 8'h00; pend_win[i] = 8'h00;
    end

    // Reset state
    #3;
    chk("reset_dout", dout, 8'h00);
    chk("reset_dout_valid", {7'd0, dout_valid}, 8'h00);
    chk("reset_border_flag", {7'd0, border_flag}, 8'h00);
    #9 rst_p = 1'b0;

    // 1: uniform 90 over a full frame started by a lone frame_start
    step(0, 1, 1);
    fill_const(8'd90);
    for (int i = 0; i < W * H; i++) step(1, 0, 1);
    drain();

    // 3: border map; partial line first, then frame_start with the first window
    rand_stream(3);
    drain();
    flag_cnt = 0;
    fill_rand();
    step(1, 0, 1);
    fill_rand();
    step(1, 1, 1);
    rand_stream(W * H - 2);
    drain();
    chk("border_count", 8'(flag_cnt), 8'd24);

    // 2: arithmetic corners at non-border positions (2..6, row 2)
    step(0, 1, 1);
    rand_stream(2 * W + 2);
    fill_const(8'd255); step(1, 0, 1);
    fill_const(8'd0);   step(1, 0, 1);
    fill_const(8'd2); next_win[4] = 8'd1; step(1, 0, 1);
    fill_const(8'd2);   step(1, 0, 1);
    fill_const(8'd255); next_win[8] = 8'd254; step(1, 0, 1);
    drain();

    // 4: gapped strobes, one every third cycle
    for (int i = 0; i < 12; i++) begin
      fill_rand();
      step(1, 0, 1);
      step(0, 0, 1);
      step(0, 0, 1);
    end
    drain();

    // 5: filter_en low for one cycle with three pixels in flight
    step(0, 1, 1);
    rand_stream(20);
    drain();
    rand_stream(3);
    fill_rand();
    step(1, 0, 0);
    rand_stream(12);
    drain();

    // 6: asynchronous reset in mid-stream, restart without frame_start
    step(0, 1, 1);
    rand_stream(22);
    async_reset();
    rand_stream(12);
    drain();

    // 7: threshold level around an all-100 window
    thr = 8'd100;
    step(0, 1, 1);
    rand_stream(2 * W + 2);
    fill_const(8'd100);
    for (int i = 0; i < 3; i++) step(1, 0, 1);
    drain();
    thr = 8'd101;
    for (int i = 0; i < 3; i++) step(1, 0, 1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
